dec_syndrome: RTL and testbench

- Front end of the Reed-Solomon decoder; the receive-side counterpart of the encoder parity processor.
- Accepts a received codeword DEC_SYM symbols per beat, highest-degree symbol first, using the same chunking as the encoder: the first beat is partial, the rest are full.
- Computes the 2t syndromes S_j = r(alpha^(RSC_FCR+j)) by per-beat Horner accumulation.
- Presents the syndrome vector, plus a zero flag, to the key-equation solver through a valid/ready handshake.

---
 rtl/dec_syndrome_pkg.sv | 49 ++++
 rtl/dec_syndrome_if.sv | 25 ++
 rtl/dec_syn_step.sv | 33 +++
 rtl/dec_syndrome.sv | 84 ++++++++
 tb/tb_dec_syndrome.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dec_syndrome_pkg.sv
// Shared Reed-Solomon definitions: field and code parameters, GF(2^m)
// arithmetic helpers, and the decoder front-end beat geometry.
package dec_syndrome_pkg;

    // Field and code parameters shared by encoder and decoder.
    localparam int              EGF_DIM     = 8;
    localparam logic [EGF_DIM:0] EGF_PRI_POL = 9'h11D;
    localparam int              RSC_COD_LEN = 255;
    localparam int              RSC_PAR_LEN = 32;
    localparam int              RSC_FCR     = 0;

    // Decoder beat geometry: the first beat carries the remainder symbols.
    localparam int DEC_SYM     = 8;
    localparam int DEC_REM     = RSC_COD_LEN % DEC_SYM;
    localparam int DEC_BEATS   = (RSC_COD_LEN + DEC_SYM - 1) / DEC_SYM;
    localparam int DEC_FIRST_K = (DEC_REM == 0) ? DEC_SYM : DEC_REM;
    localparam int DEC_CNT_W   = (DEC_BEATS > 1) ? $clog2(DEC_BEATS) : 1;

    typedef logic [EGF_DIM-1:0]                  egf_sym_t;
    typedef logic [DEC_SYM-1:0][EGF_DIM-1:0]     dec_beat_t;
    typedef logic [RSC_PAR_LEN-1:0][EGF_DIM-1:0] dec_syn_t;

    // Shift-and-add multiply in GF(2^m), reducing by the primitive polynomial.
    function automatic egf_sym_t egf_mul(input egf_sym_t a, input egf_sym_t b);
        egf_sym_t prod;
        egf_sym_t mcand;
        prod  = '0;
        mcand = a;
        for (int i = 0; i < EGF_DIM; i++) begin
            if (b[i]) prod = prod ^ mcand;
            if (mcand[EGF_DIM-1])
                mcand = {mcand[EGF_DIM-2:0], 1'b0} ^ EGF_PRI_POL[EGF_DIM-1:0];
            else
                mcand = {mcand[EGF_DIM-2:0], 1'b0};
        end
        return prod;
    endfunction

    // alpha^e_in; only evaluated at elaboration time for constant coefficients.
    function automatic egf_sym_t egf_pow(input int unsigned e_in);
        egf_sym_t    res;
        int unsigned e;
        res = egf_sym_t'(1);
        e   = e_in % ((1 << EGF_DIM) - 1);
        for (int unsigned k = 0; k < e; k++) res = egf_mul(res, egf_sym_t'(2));
        return res;
    endfunction

endpackage

// File: rtl/dec_syndrome_if.sv
// Beat input and syndrome output handshakes of the syndrome front end.
interface dec_syndrome_if;
    import dec_syndrome_pkg::*;

    logic      in_valid;
    logic      in_ready;
    dec_beat_t in_data;
    logic      syn_valid;
    logic      syn_ready;
    dec_syn_t  syn_data;
    logic      syn_zero;

    // Upstream source of beats and downstream sink of syndromes.
    modport master (
        output in_valid, in_data, syn_ready,
        input  in_ready, syn_valid, syn_data, syn_zero
    );

    // The syndrome calculator itself.
    modport slave (
        input  in_valid, in_data, syn_ready,
        output in_ready, syn_valid, syn_data, syn_zero
    );

endinterface

// File: rtl/dec_syn_step.sv
// One Horner step over a whole beat for all 2t syndromes:
// acc_j' = acc_j * a^((FCR+j)*K) ^ sum_i data[i] * a^((FCR+j)*i).
// On the first beat the accumulator is dropped and only the low lanes count.
module dec_syn_step
    import dec_syndrome_pkg::*;
(
    input  dec_syn_t  acc_i,
    input  dec_beat_t data_i,
    input  logic      first_i,
    output dec_syn_t  acc_o
);

    for (genvar j = 0; j < RSC_PAR_LEN; j++) begin : g_syn
        localparam egf_sym_t MUL_K = egf_pow((RSC_FCR + j) * DEC_SYM);

        egf_sym_t part [DEC_SYM+1];

        // Carried term: previous accumulator advanced by one full beat.
        assign part[0] = first_i ? '0 : egf_mul(acc_i[j], MUL_K);

        for (genvar i = 0; i < DEC_SYM; i++) begin : g_lane
            localparam egf_sym_t LANE_C    = egf_pow((RSC_FCR + j) * i);
            localparam bit       ALWAYS_ON = (i < DEC_FIRST_K);

            // Lanes above the remainder are ignored on the partial first beat.
            assign part[i+1] = part[i] ^
                ((ALWAYS_ON || !first_i) ? egf_mul(data_i[i], LANE_C) : '0);
        end

        assign acc_o[j] = part[DEC_SYM];
    end

endmodule

// File: rtl/dec_syndrome.sv
// Reed-Solomon syndrome front end: accumulates a codeword beat by beat
// (highest degree first) and hands the 2t syndromes plus a zero flag
// downstream through a valid/ready handshake.
module dec_syndrome
    import dec_syndrome_pkg::*;
(
    input logic           clk,
    input logic           rst_n,
    dec_syndrome_if.slave bus
);

    logic [DEC_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    dec_syn_t             acc_q, acc_d;
    logic                 syn_valid_q, syn_valid_d;
    dec_syn_t             syn_data_q, syn_data_d;
    logic                 syn_zero_q, syn_zero_d;

    logic     in_ready;
    logic     beat_fire;
    logic     first_beat;
    logic     last_beat;
    dec_syn_t acc_nxt;

    // Any beat stalls while a finished set waits, so only one codeword is in flight.
    assign in_ready   = !(syn_valid_q && !bus.syn_ready);
    assign beat_fire  = bus.in_valid && in_ready;
    assign first_beat = (beat_cnt_q == '0);
    assign last_beat  = (beat_cnt_q == DEC_CNT_W'(DEC_BEATS - 1));

    dec_syn_step u_step (
        .acc_i   (acc_q),
        .data_i  (bus.in_data),
        .first_i (first_beat),
        .acc_o   (acc_nxt)
    );

    // Next-state: advance on each accepted beat, publish on the last one.
    always_comb begin
        // NOTE: every _d starts from its hold value so no branch can infer a latch.
        beat_cnt_d  = beat_cnt_q;
        acc_d       = acc_q;
        syn_valid_d = syn_valid_q;
        syn_data_d  = syn_data_q;
        syn_zero_d  = syn_zero_q;

        if (bus.syn_ready) syn_valid_d = 1'b0;

        if (beat_fire) begin
            acc_d      = acc_nxt;
            beat_cnt_d = last_beat ? '0 : beat_cnt_q + DEC_CNT_W'(1);
            if (last_beat) begin
                syn_valid_d = 1'b1;
                syn_data_d  = acc_nxt;
                syn_zero_d  = (acc_nxt == '0);
            end
        end
    end

    // State registers; a reset discards any partially received codeword.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q  <= '0;
            // NOTE: the wide data registers are reset too, so the output bus is
            // defined from the first cycle rather than left as power-up garbage.
            acc_q       <= '0;
            syn_valid_q <= 1'b0;
            syn_data_q  <= '0;
            syn_zero_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            beat_cnt_q  <= beat_cnt_d;
            acc_q       <= acc_d;
            syn_valid_q <= syn_valid_d;
            syn_data_q  <= syn_data_d;
            syn_zero_q  <= syn_zero_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.syn_valid = syn_valid_q;
    assign bus.syn_data  = syn_data_q;
    assign bus.syn_zero  = syn_zero_q;

endmodule

// File: tb/tb_dec_syndrome.sv
// Scoreboard bench for dec_syndrome: codewords built by a degree-indexed
// polynomial model, syndromes computed by direct evaluation r(alpha^(FCR+j)).
module tb_dec_syndrome;
    import dec_syndrome_pkg::*;

    typedef struct packed {
        dec_syn_t syn;
        logic     zero;
    } exp_t;

    logic clk;
    logic rst_n;
    dec_syndrome_if bus ();

    dec_syndrome u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Log/antilog tables of GF(256) and the generator polynomial.
    logic [7:0] gexp [512];
    int         glog [256];
    logic [7:0] gen  [RSC_PAR_LEN+1];
    logic [7:0] cw_buf [RSC_COD_LEN];   // index = polynomial degree

    exp_t     exp_q [$];
    dec_syn_t last_syn;
    logic     last_zero;
    int       n_sets = 0;
    int       stall_cycles = 0;
    int       blocked_cycles = 0;

    bit rand_ready = 0;
    bit use_gaps   = 0;
    int stall_left = 0;

    task automatic check(input string name, input logic [RSC_PAR_LEN*EGF_DIM-1:0] act,
                         input logic [RSC_PAR_LEN*EGF_DIM-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 0 || b == 0) return 8'h00;
        return gexp[glog[a] + glog[b]];
    endfunction

    function automatic void init_tables();
        int x;
        x = 1;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = x[7:0];
            glog[x] = i;
            x = x << 1;
            if (x & 'h100) x = x ^ 'h11D;
        end
        for (int i = 255; i < 512; i++) gexp[i] = gexp[i-255];
        glog[0] = 0;
        for (int t = 0; t <= RSC_PAR_LEN; t++) gen[t] = 8'h00;
        gen[0] = 8'h01;
        for (int j = 0; j < RSC_PAR_LEN; j++) begin
            logic [7:0] root;
            root = gexp[(RSC_FCR + j) % 255];
            for (int t = j + 1; t >= 1; t--) gen[t] = gen[t-1] ^ gmul(gen[t], root);
            gen[0] = gmul(gen[0], root);
        end
    endfunction

    // Systematic encode: message already in cw_buf[32..254]; fills the parity.
    function automatic void encode();
        logic [7:0] work [RSC_COD_LEN];
        for (int k = 0; k < RSC_COD_LEN; k++) work[k] = (k >= RSC_PAR_LEN) ? cw_buf[k] : 8'h00;
        for (int d = RSC_COD_LEN - 1; d >= RSC_PAR_LEN; d--) begin
            logic [7:0] c;
            c = work[d];
            if (c != 0)
                for (int t = 0; t <= RSC_PAR_LEN; t++)
                    work[d - RSC_PAR_LEN + t] = work[d - RSC_PAR_LEN + t] ^ gmul(c, gen[t]);
        end
        for (int k = 0; k < RSC_PAR_LEN; k++) cw_buf[k] = work[k];
    endfunction

    function automatic exp_t ref_syndromes();
        exp_t e;
        e.syn = '0;
        for (int j = 0; j < RSC_PAR_LEN; j++) begin
            logic [7:0] s;
            s = 8'h00;
            for (int k = 0; k < RSC_COD_LEN; k++)
                s = s ^ gmul(cw_buf[k], gexp[((RSC_FCR + j) * k) % 255]);
            e.syn[j] = s;
        end
        e.zero = (e.syn == '0);
        return e;
    endfunction

    function automatic void fill_zero();
        for (int k = 0; k < RSC_COD_LEN; k++) cw_buf[k] = 8'h00;
    endfunction

    function automatic void fill_random_valid();
        for (int k = RSC_PAR_LEN; k < RSC_COD_LEN; k++) cw_buf[k] = 8'($urandom);
        encode();
    endfunction

    // Drives beats 0..n_beats-1 of cw_buf; called at posedge+1.
    task automatic send_beats(input int n_beats);
        for (int b = 0; b < n_beats; b++) begin
            dec_beat_t beat;
            int        guard;
            bit        rdy;
            if (use_gaps && $urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_data  = dec_beat_t'({$urandom, $urandom});
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            for (int i = 0; i < DEC_SYM; i++) begin
                if (b == 0 && i >= DEC_FIRST_K) beat[i] = 8'($urandom);
                else                            beat[i] = cw_buf[(DEC_BEATS - 1 - b) * DEC_SYM + i];
            end
            bus.in_valid = 1'b1;
            bus.in_data  = beat;
            guard = 0;
            do begin
                @(negedge clk);
                rdy = bus.in_ready;
                @(posedge clk);
                #1;
                guard++;
            end while (!rdy && guard < 1000);
            if (!rdy) begin
                n_checks++;
                n_errors++;
                $display("FAIL beat accept timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_cw();
        exp_q.push_back(ref_syndromes());
        send_beats(DEC_BEATS);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        #1;
        check("scoreboard drained", 256'(exp_q.size()), '0);
    endtask

    task automatic reset_values_check();
        @(negedge clk);
        check("reset syn_valid", 256'(bus.syn_valid), '0);
        check("reset syn_zero", 256'(bus.syn_zero), '0);
        check("reset syn_data", bus.syn_data, '0);
        check("reset in_ready", 256'(bus.in_ready), 256'(1));
        @(posedge clk);
        #1;
    endtask

    // Downstream ready: optional forced stall once a set is presented, else random or high.
    initial begin : ready_gen
        bus.syn_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0 && bus.syn_valid) begin
                bus.syn_ready = 1'b0;
                stall_left--;
            end else if (rand_ready) begin
                bus.syn_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.syn_ready = 1'b1;
            end
        end
    end

    // Monitor: latency, hold-under-backpressure, ready rule, and scoreboard pops.
    initial begin : monitor
        int       mon_beats;
        bit       expect_valid;
        bit       stall_prev;
        dec_syn_t prev_data;
        logic     prev_zero;
        mon_beats = 0;
        expect_valid = 0;
        stall_prev = 0;
        prev_data = '0;
        prev_zero = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_beats = 0;
                expect_valid = 0;
                stall_prev = 0;
            end else begin
                if (expect_valid) check("syn_valid one cycle after last beat", 256'(bus.syn_valid), 256'(1));
                expect_valid = 0;
                if (stall_prev) begin
                    check("stalled syn_valid held", 256'(bus.syn_valid), 256'(1));
                    check("stalled syn_data held", bus.syn_data, prev_data);
                    check("stalled syn_zero held", 256'(bus.syn_zero), 256'(prev_zero));
                end
                check("in_ready backpressure rule", 256'(bus.in_ready),
                      256'(!(bus.syn_valid && !bus.syn_ready)));
                if (bus.syn_valid && bus.syn_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected syndrome set: got %0h with no codeword outstanding", bus.syn_data);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("syn_data", bus.syn_data, e.syn);
                        check("syn_zero", 256'(bus.syn_zero), 256'(e.zero));
                    end
                    last_syn  = bus.syn_data;
                    last_zero = bus.syn_zero;
                    n_sets++;
                end
                stall_prev = bus.syn_valid && !bus.syn_ready;
                prev_data  = bus.syn_data;
                prev_zero  = bus.syn_zero;
                if (bus.syn_valid && !bus.syn_ready) stall_cycles++;
                if (bus.in_valid && !bus.in_ready) blocked_cycles++;
                if (bus.in_valid && bus.in_ready) begin
                    mon_beats++;
                    if (mon_beats == DEC_BEATS) begin
                        mon_beats = 0;
                        expect_valid = 1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int nz;
        init_tables();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_values_check();

        // All-zero codeword, back to back.
        fill_zero();
        send_cw();
        drain();
        check("all-zero syn_zero", 256'(last_zero), 256'(1));

        // Encoded message 1..223, highest degree first.
        for (int n = 1; n <= RSC_COD_LEN - RSC_PAR_LEN; n++) cw_buf[RSC_COD_LEN - n] = 8'(n);
        encode();
        send_cw();
        drain();
        check("encoded codeword syn_zero", 256'(last_zero), 256'(1));
        check("encoded codeword syn_data", last_syn, '0);

        // Single 0x01 at degree 1: S_j = alpha^j.
        fill_zero();
        cw_buf[1] = 8'h01;
        send_cw();
        drain();
        check("degree1 S_0", 256'(last_syn[0]), 256'(8'h01));
        check("degree1 S_1", 256'(last_syn[1]), 256'(8'h02));
        check("degree1 S_2", 256'(last_syn[2]), 256'(8'h04));
        check("degree1 S_8", 256'(last_syn[8]), 256'(8'h1D));
        check("degree1 syn_zero", 256'(last_zero), '0);

        // Valid codeword with error 0x5A at degree 254 (beat 0, lane 6).
        for (int n = 1; n <= RSC_COD_LEN - RSC_PAR_LEN; n++) cw_buf[RSC_COD_LEN - n] = 8'(n);
        encode();
        cw_buf[254] = cw_buf[254] ^ 8'h5A;
        send_cw();
        drain();
        check("error S_0", 256'(last_syn[0]), 256'(8'h5A));
        nz = 0;
        for (int j = 0; j < RSC_PAR_LEN; j++) if (last_syn[j] == 8'h00) nz++;
        check("error all syndromes nonzero (zero count)", 256'(nz), '0);

        // Downstream stalls 5 cycles while the next codeword streams in.
        stall_cycles = 0;
        blocked_cycles = 0;
        stall_left = 5;
        fill_random_valid();
        cw_buf[$urandom_range(0, RSC_COD_LEN - 1)] ^= 8'($urandom_range(1, 255));
        send_cw();
        fill_random_valid();
        cw_buf[$urandom_range(0, RSC_COD_LEN - 1)] ^= 8'($urandom_range(1, 255));
        send_cw();
        drain();
        check("stall cycles observed", 256'(stall_cycles >= 5), 256'(1));
        check("in_ready dropped during stall", 256'(blocked_cycles > 0), 256'(1));

        // Randomized mix with gaps and random backpressure.
        rand_ready = 1;
        use_gaps   = 1;
        for (int c = 0; c < 20; c++) begin
            int kind;
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                for (int k = 0; k < RSC_COD_LEN; k++) cw_buf[k] = 8'($urandom);
            end else begin
                fill_random_valid();
                if (kind == 2)
                    repeat ($urandom_range(1, 16))
                        cw_buf[$urandom_range(0, RSC_COD_LEN - 1)] ^= 8'($urandom_range(1, 255));
            end
            send_cw();
        end
        drain();
        rand_ready = 0;
        use_gaps   = 0;

        // Reset after 10 beats of a nonzero codeword, then a clean codeword.
        for (int k = 0; k < RSC_COD_LEN; k++) cw_buf[k] = 8'($urandom_range(1, 255));
        send_beats(10);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_values_check();
        fill_random_valid();
        send_cw();
        drain();
        check("post-reset syn_zero", 256'(last_zero), 256'(1));
        check("syndrome sets delivered", 256'(n_sets), 256'(27));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
